// File: rtl/adder_pkg.sv
// Shared constants for the adder family.
package adder_pkg;
   localparam int unsigned RCA_WIDTH     = 4;
   localparam int unsigned RCA_RES_WIDTH = RCA_WIDTH + 1;
endpackage : adder_pkg

// File: rtl/full_adder.sv
// One-bit full adder cell; the ripple chain is built from these.
module full_adder (
   input  logic a,
   input  logic b,
   input  logic cin,
   output logic s,
   output logic cout
);
   logic p;

   always_comb begin
      p    = a ^ b;
      s    = p ^ cin;
      cout = (a & b) | (cin & p);
   end
endmodule : full_adder

// File: rtl/ripple_carry_adder4.sv
// 4-bit ripple-carry adder with one registered output stage.
// Produces sum, carry-out and signed overflow one cycle after in_valid.
module ripple_carry_adder4
   import adder_pkg::*;
#(
   parameter int unsigned WIDTH = RCA_WIDTH
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             in_valid,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   input  logic             cin,
   output logic             out_valid,
   output logic [WIDTH-1:0] sum,
   output logic             cout,
   output logic             ovf
);
   logic [WIDTH:0]   c;
   logic [WIDTH-1:0] s;

   logic             out_valid_d, out_valid_q;
   logic [WIDTH-1:0] sum_d, sum_q;
   logic             cout_d, cout_q;
   logic             ovf_d, ovf_q;

   assign c[0] = cin;

   for (genvar i = 0; i < WIDTH; i++) begin : g_chain
      full_adder u_fa (
         .a    (a[i]),
         .b    (b[i]),
         .cin  (c[i]),
         .s    (s[i]),
         .cout (c[i+1])
      );
   end

   // Operands are only looked at when in_valid is high, so X on idle inputs never reaches the flops.
   always_comb begin
      out_valid_d = in_valid;
      sum_d       = sum_q;
      cout_d      = cout_q;
      ovf_d       = ovf_q;
      if (in_valid) begin
         sum_d  = s;
         cout_d = c[WIDTH];
         ovf_d  = c[WIDTH-1] ^ c[WIDTH];
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         out_valid_q <= 1'b0;
         sum_q       <= '0;
         cout_q      <= 1'b0;
         ovf_q       <= 1'b0;
      end else begin
         out_valid_q <= out_valid_d;
         sum_q       <= sum_d;
         cout_q      <= cout_d;
         ovf_q       <= ovf_d;
      end
   end

   assign out_valid = out_valid_q;
   assign sum       = sum_q;
   assign cout      = cout_q;
   assign ovf       = ovf_q;
endmodule : ripple_carry_adder4

// File: tb/tb_ripple_carry_adder4.sv
// Directed and exhaustive checks of ripple_carry_adder4.
// Results are compared packed as {out_valid, cout, ovf, sum[3:0]}.
module tb_ripple_carry_adder4;
   logic       clk = 1'b0;
   logic       rst_n;
   logic       in_valid;
   logic [3:0] a, b;
   logic       cin;
   logic       out_valid;
   logic [3:0] sum;
   logic       cout;
   logic       ovf;

   int unsigned n_cmp = 0;
   int unsigned n_bad = 0;
   logic [6:0]  last_exp = '0;

   always #5 clk = ~clk;

   ripple_carry_adder4 #(.WIDTH(4)) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .in_valid  (in_valid),
      .a         (a),
      .b         (b),
      .cin       (cin),
      .out_valid (out_valid),
      .sum       (sum),
      .cout      (cout),
      .ovf       (ovf)
   );

   task automatic check_eq(input string tag, input logic [6:0] obs, input logic [6:0] exp);
      n_cmp++;
      if (obs !== exp) begin
         n_bad++;
         $display("FAIL %s: got {v,co,ovf,sum}=%b expected %b", tag, obs, exp);
      end
   endtask

   function automatic logic [6:0] ref_res(input logic [3:0] ra, input logic [3:0] rb, input logic rc);
      logic [4:0] t;
      logic       v;
      t = {1'b0, ra} + {1'b0, rb} + {4'b0000, rc};
      v = (ra[3] == rb[3]) && (t[3] != ra[3]);
      return {1'b1, t[4], v, t[3:0]};
   endfunction

   function automatic logic [6:0] observed();
      return {out_valid, cout, ovf, sum};
   endfunction

   task automatic apply(input string tag, input logic [3:0] va, input logic [3:0] vb,
                        input logic vc, input logic [6:0] exp);
      @(negedge clk);
      in_valid = 1'b1; a = va; b = vb; cin = vc;
      @(posedge clk);
      #1;
      check_eq(tag, observed(), exp);
      last_exp = exp;
   endtask

   task automatic idle(input string tag, input logic [3:0] va, input logic [3:0] vb, input logic vc);
      @(negedge clk);
      in_valid = 1'b0; a = va; b = vb; cin = vc;
      @(posedge clk);
      #1;
      check_eq(tag, observed(), {1'b0, last_exp[5:0]});
   endtask

   initial begin
      rst_n = 1'b0; in_valid = 1'b0; a = '0; b = '0; cin = 1'b0;
      #2;
      check_eq("reset_init", observed(), 7'b0_0_0_0000);
      in_valid = 1'b1; a = 4'b1111; b = 4'b1111; cin = 1'b1;
      @(posedge clk);
      #1;
      check_eq("reset_hold_edge", observed(), 7'b0_0_0_0000);
      @(negedge clk);
      rst_n = 1'b1; in_valid = 1'b0;

      apply("wrap",      4'b1111, 4'b0001, 1'b0, 7'b1_1_0_0000);
      idle ("wrap_idle", 4'b0101, 4'b1010, 1'b1);
      apply("cin_only",  4'b0000, 4'b0000, 1'b1, 7'b1_0_0_0001);
      apply("zero",      4'b0000, 4'b0000, 1'b0, 7'b1_0_0_0000);
      apply("maximum",   4'b1111, 4'b1111, 1'b1, 7'b1_1_0_1111);
      apply("ovf_pos",   4'b0111, 4'b0001, 1'b0, 7'b1_0_1_1000);
      apply("ovf_neg",   4'b1000, 4'b1000, 1'b0, 7'b1_1_1_0000);
      apply("mixed",     4'b0110, 4'b1011, 1'b1, 7'b1_1_0_0010);

      idle("idle_x",      4'bxxxx, 4'bxxxx, 1'bx);
      idle("idle_toggle", 4'b1111, 4'b1111, 1'b1);
      idle("idle_x2",     4'bx0x1, 4'b1x0x, 1'bx);

      for (int i = 0; i < 512; i++) begin
         logic [8:0] v;
         v = 9'(i);
         apply($sformatf("exh_%0d", i), v[8:5], v[4:1], v[0], ref_res(v[8:5], v[4:1], v[0]));
      end

      apply("pre_reset_max", 4'b1111, 4'b1111, 1'b1, 7'b1_1_0_1111);
      @(negedge clk);
      in_valid = 1'b0;
      #2;
      rst_n = 1'b0;
      #1;
      check_eq("async_reset", observed(), 7'b0_0_0_0000);
      @(posedge clk);
      #1;
      check_eq("async_reset_held", observed(), 7'b0_0_0_0000);
      @(negedge clk);
      rst_n = 1'b1;
      apply("post_reset", 4'b0011, 4'b0100, 1'b0, 7'b1_0_0_0111);
      idle ("post_reset_idle", 4'bxxxx, 4'b0000, 1'b0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end
endmodule : tb_ripple_carry_adder4
